sd_spi_cmd_engine: RTL and testbench
====================================

// Module: sd_spi_cmd_engine
// PURPOSE
//  Parametrised SD-over-SPI command engine: issues one 48-bit SD command (auto CRC7), polls for R1,
//  optionally captures 4 trailing response bytes (R3/R7), with optional 0xFF preamble (cs high).
//  Has its own SPI mode-0 shifter and clock divider; sits under the SD init/sector FSM.
// PARAMETERS
//  CLK_DIV      4   clk cycles per spi_clk half-period (>=2)
//  INIT_BYTES   10  0xFF bytes sent with cs high when init_mode=1 (10 = 80 spi clocks)
//  RESP_TIMEOUT 8   max response-poll bytes (Ncr) before timeout (1..255)
// PORTS
//  clk         in   1   master clock
//  rst_n       in   1   asynchronous active-low reset
//  cmd_start   in   1   1-cycle request; sampled only in IDLE
//  init_mode   in   1   prepend INIT_BYTES preamble (sampled with cmd_start)
//  cmd_index   in   6   SD command number
//  cmd_arg     in   32  command argument
//  resp_long   in   1   0: R1 only; 1: R1 + 4 bytes (R3/R7)
//  busy        out  1   high from accepted cmd_start until cmd_done
//  cmd_done    out  1   1-cycle pulse at completion
//  timeout_err out  1   valid with cmd_done; no R1 within RESP_TIMEOUT bytes
//  resp_r1     out  8   R1 byte (0xFF on timeout)
//  resp_data   out  32  trailing bytes, MSB-first (0 if resp_long=0 or timeout)
//  spi_clk     out  1   SPI clock, idle low
//  mosi        out  1   idle high
//  miso        in   1   sampled on spi_clk rising edge
//  cs          out  1   active-low chip select
// BEHAVIOUR
//  - Reset: busy=0, cmd_done=0, timeout_err=0, resp_r1=8'hFF, resp_data=0, spi_clk=0, mosi=1, cs=1,
//    FSM=IDLE. Reset mid-command aborts immediately, no trailing clocks.
//  - Inputs latched on accepted cmd_start; busy rises next cycle; cmd_start while busy ignored.
//  - Byte shifter: MSB first, 16*CLK_DIV clk per byte; mosi updates on spi_clk falling edge
//    (first bit set before first rising edge); miso sampled on rising edge; spi_clk ends low.
//  - States: IDLE -> PREAMBLE (if init_mode) -> CMD_TX -> RESP_WAIT -> [RESP_RX] -> TRAIL -> DONE -> IDLE.
//  - PREAMBLE: INIT_BYTES x 0xFF, cs=1. cs drops one clk before first CMD_TX spi_clk edge.
//  - CMD_TX: 6 bytes {2'b01,cmd_index}, arg[31:24..7:0], {crc7,1'b1}; CRC7 poly x^7+x^3+1, init 0,
//    over first 40 bits, computed serially as bits shift or precomputed at latch (either; result fixed).
//  - RESP_WAIT: send 0xFF bytes; first byte with bit7=0 -> resp_r1. RESP_TIMEOUT bytes all with bit7=1
//    -> timeout_err=1, resp_r1=8'hFF, skip RESP_RX.
//  - RESP_RX (resp_long=1, no timeout): 4 more 0xFF bytes, captured into resp_data MSB-first.
//  - TRAIL: one 0xFF byte with cs=0 (8 clocks), then cs=1.
//  - DONE: cmd_done=1 one cycle, busy=0 same cycle; resp_r1/resp_data/timeout_err hold until next
//    accepted cmd_start (timeout_err cleared, resp_data cleared on accept).
//  - Counters saturate-free: byte count 8-bit, compared with ==; RESP_TIMEOUT=1 allows exactly 1 poll.
//  - cmd_start in same cycle as cmd_done: ignored (busy logic uses registered state = DONE).
// TESTING
//  1 init_mode=1, CMD0 arg=0, miso=0xFF x1 then 0x01 -> 80 spi clks cs=1, mosi 40 00 00 00 00 95,
//    resp_r1=0x01, timeout_err=0, cmd_done one pulse.
//  2 CMD8 arg=0x000001AA resp_long=1, miso: FF,01,00,00,01,AA -> mosi 48 00 00 01 AA 87,
//    resp_r1=0x01, resp_data=0x000001AA.
//  3 CMD55 then ACMD41 arg=0x40000000, miso R1=0x00 -> bytes 77 00 00 00 00 65 / 69 40 00 00 00 77.
//  4 miso held high, RESP_TIMEOUT=8 -> exactly 8 poll bytes, timeout_err=1, resp_r1=0xFF, cs=1 after TRAIL.
//  5 rst_n low mid CMD_TX byte 3 -> cs=1, spi_clk=0, mosi=1, busy=0 asynchronously; new cmd ok after.
//  6 cmd_start pulsed while busy and on cmd_done cycle -> no second command; CLK_DIV=2 and 7 rerun test 1.

Source files
------------

// File: rtl/sd_spi_cmd_engine.sv
// rtl/sd_spi_cmd_engine.sv - SD-over-SPI command engine: CRC7 command frame, R1 poll, optional R3/R7 tail
module sd_spi_cmd_engine #(
    parameter int CLK_DIV      = 4,
    parameter int INIT_BYTES   = 10,
    parameter int RESP_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_start,
    input  logic        init_mode,
    input  logic [5:0]  cmd_index,
    input  logic [31:0] cmd_arg,
    input  logic        resp_long,
    output logic        busy,
    output logic        cmd_done,
    output logic        timeout_err,
    output logic [7:0]  resp_r1,
    output logic [31:0] resp_data,
    output logic        spi_clk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs
);

    localparam int             DW        = $clog2(CLK_DIV);
    localparam logic [DW-1:0]  DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [7:0]     INIT_LAST = 8'(INIT_BYTES - 1);
    localparam logic [7:0]     POLL_LAST = 8'(RESP_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_CMD_TX, S_RESP_WAIT, S_RESP_RX, S_TRAIL, S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [DW-1:0]  div_q, div_d;
    logic           sclk_q, sclk_d;
    logic [2:0]     bit_q, bit_d;
    logic [7:0]     tx_q, tx_d;
    logic [7:0]     rx_q, rx_d;
    logic [7:0]     cnt_q, cnt_d;
    logic [47:0]    cmd_q, cmd_d;
    logic           long_q, long_d;
    logic           cs_q, cs_d;
    logic [7:0]     r1_q, r1_d;
    logic [31:0]    data_q, data_d;
    logic           tmo_q, tmo_d;

    logic           active, rise, fall, byte_end;
    logic [39:0]    crc_in;
    logic [47:0]    frame;

    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = '0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    assign crc_in   = {2'b01, cmd_index, cmd_arg};
    assign frame    = {crc_in, crc7(crc_in), 1'b1};
    assign active   = state_q inside {S_PREAMBLE, S_CMD_TX, S_RESP_WAIT, S_RESP_RX, S_TRAIL};
    assign rise     = active && !sclk_q && (div_q == DIV_LAST);
    assign fall     = active && sclk_q && (div_q == DIV_LAST);
    assign byte_end = fall && (bit_q == 3'd7);

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sclk_d  = sclk_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        long_d  = long_q;
        r1_d    = r1_q;
        data_d  = data_q;
        tmo_d   = tmo_q;

        // Bit engine: a byte ends with spi_clk low and all counters wrapped to zero.
        if (active) begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            if (rise) begin
                sclk_d = 1'b1;
                rx_d   = {rx_q[6:0], miso};
            end
            if (fall) begin
                sclk_d = 1'b0;
                bit_d  = bit_q + 3'd1;
                tx_d   = {tx_q[6:0], 1'b1};
            end
            if (byte_end) cnt_d = cnt_q + 8'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    cmd_d  = frame;
                    long_d = resp_long;
                    tmo_d  = 1'b0;
                    data_d = '0;
                    cnt_d  = '0;
                    if (init_mode) begin
                        state_d = S_PREAMBLE;
                        tx_d    = 8'hFF;
                    end else begin
                        state_d = S_CMD_TX;
                        tx_d    = frame[47:40];
                    end
                end
            end
            S_PREAMBLE: begin
                if (byte_end && cnt_q == INIT_LAST) begin
                    state_d = S_CMD_TX;
                    cnt_d   = '0;
                    tx_d    = cmd_q[47:40];
                end
            end
            S_CMD_TX: begin
                if (byte_end) begin
                    if (cnt_q == 8'd5) begin
                        state_d = S_RESP_WAIT;
                        cnt_d   = '0;
                        tx_d    = 8'hFF;
                    end else begin
                        cmd_d = {cmd_q[39:0], 8'h00};
                        tx_d  = cmd_q[39:32];
                    end
                end
            end
            S_RESP_WAIT: begin
                if (byte_end) begin
                    if (!rx_q[7]) begin
                        r1_d    = rx_q;
                        cnt_d   = '0;
                        state_d = long_q ? S_RESP_RX : S_TRAIL;
                    end else if (cnt_q == POLL_LAST) begin
                        r1_d    = 8'hFF;
                        tmo_d   = 1'b1;
                        cnt_d   = '0;
                        state_d = S_TRAIL;
                    end
                end
            end
            S_RESP_RX: begin
                if (byte_end) begin
                    data_d = {data_q[23:0], rx_q};
                    if (cnt_q == 8'd3) begin
                        cnt_d   = '0;
                        state_d = S_TRAIL;
                    end
                end
            end
            S_TRAIL: begin
                if (byte_end) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        cs_d = !(state_d inside {S_CMD_TX, S_RESP_WAIT, S_RESP_RX, S_TRAIL});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            sclk_q  <= 1'b0;
            bit_q   <= '0;
            tx_q    <= 8'hFF;
            rx_q    <= 8'hFF;
            cnt_q   <= '0;
            cmd_q   <= '0;
            long_q  <= 1'b0;
            cs_q    <= 1'b1;
            r1_q    <= 8'hFF;
            data_q  <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sclk_q  <= sclk_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            long_q  <= long_d;
            cs_q    <= cs_d;
            r1_q    <= r1_d;
            data_q  <= data_d;
            tmo_q   <= tmo_d;
        end
    end

    // DONE is excluded from busy so a cmd_start in the done cycle is never taken.
    assign busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign cmd_done    = (state_q == S_DONE);
    assign timeout_err = tmo_q;
    assign resp_r1     = r1_q;
    assign resp_data   = data_q;
    assign spi_clk     = sclk_q;
    assign mosi        = tx_q[7];
    assign cs          = cs_q;

endmodule

// File: tb/tb_sd_spi_cmd_engine.sv
// tb/tb_sd_spi_cmd_engine.sv - three parameter sets driven in parallel against a byte-level SD card model
module tb_sd_spi_cmd_engine;

    function automatic int ib_f(input int g);
        return (g == 2) ? 3 : 10;
    endfunction

    function automatic int to_f(input int g);
        return (g == 2) ? 1 : 8;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cmd_start;
    logic        init_mode, resp_long;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    wire  [2:0]  busy, cmd_done, timeout_err, spi_clk, mosi, cs;
    wire  [7:0]  resp_r1 [3];
    wire  [31:0] resp_data [3];
    logic [2:0]  miso;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sd_spi_cmd_engine #(
            .CLK_DIV     (g == 0 ? 4 : (g == 1 ? 2 : 7)),
            .INIT_BYTES  (g == 2 ? 3 : 10),
            .RESP_TIMEOUT(g == 2 ? 1 : 8)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .cmd_start  (cmd_start[g]),
            .init_mode  (init_mode),
            .cmd_index  (cmd_index),
            .cmd_arg    (cmd_arg),
            .resp_long  (resp_long),
            .busy       (busy[g]),
            .cmd_done   (cmd_done[g]),
            .timeout_err(timeout_err[g]),
            .resp_r1    (resp_r1[g]),
            .resp_data  (resp_data[g]),
            .spi_clk    (spi_clk[g]),
            .mosi       (mosi[g]),
            .miso       (miso[g]),
            .cs         (cs[g])
        );
    end

    // Card model: bytes the card returns after the 6 command bytes.
    logic [7:0]  rsp [16];
    int          k [3];
    int          pre_clk [3];
    int          extra0 [3];
    int          done_cnt [3];
    int          bad_busy [3];
    logic [47:0] frame_cap [3];
    logic [2:0]  sclk_prev, busy_prev;
    int          ncmp = 0;
    int          nfail = 0;

    always_comb begin
        miso = '1;
        for (int g = 0; g < 3; g++) begin
            if (k[g] >= 48 && k[g] < 48 + 8 * 16)
                miso[g] = rsp[(k[g] - 48) / 8][7 - (k[g] % 8)];
        end
    end

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            sclk_prev[g] <= spi_clk[g];
            busy_prev[g] <= busy[g];
            if (busy[g] && !busy_prev[g]) begin
                k[g]         <= 0;
                pre_clk[g]   <= 0;
                extra0[g]    <= 0;
                done_cnt[g]  <= 0;
                bad_busy[g]  <= 0;
                frame_cap[g] <= '1;
            end else begin
                if (spi_clk[g] && !sclk_prev[g]) begin
                    if (cs[g]) begin
                        pre_clk[g] <= pre_clk[g] + 1;
                    end else begin
                        if (k[g] < 48) frame_cap[g][47 - k[g]] <= mosi[g];
                        else if (!mosi[g]) extra0[g] <= extra0[g] + 1;
                        k[g] <= k[g] + 1;
                    end
                end
                if (cmd_done[g]) begin
                    done_cnt[g] <= done_cnt[g] + 1;
                    if (busy[g]) bad_busy[g] <= bad_busy[g] + 1;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // CRC7 as the remainder of polynomial long division by x^7+x^3+1.
    function automatic logic [6:0] ref_crc7(input logic [39:0] d);
        logic [46:0] r;
        r = {d, 7'b0};
        for (int b = 46; b >= 7; b--)
            if (r[b]) r = r ^ (47'h89 << (b - 7));
        return r[6:0];
    endfunction

    task automatic set_rsp(input int gap, input logic [7:0] r1, input logic [31:0] d);
        for (int p = 0; p < 16; p++) rsp[p] = 8'hFF;
        if (gap + 4 < 16) begin
            rsp[gap]     = r1;
            rsp[gap + 1] = d[31:24];
            rsp[gap + 2] = d[23:16];
            rsp[gap + 3] = d[15:8];
            rsp[gap + 4] = d[7:0];
        end
    endtask

    task automatic start_cmd(input logic [2:0] mask, input logic im, input logic [5:0] idx,
                             input logic [31:0] arg, input logic rl);
        @(negedge clk);
        init_mode = im;
        cmd_index = idx;
        cmd_arg   = arg;
        resp_long = rl;
        cmd_start = mask;
        @(negedge clk);
        cmd_start = '0;
        init_mode = ~im;
        cmd_index = ~idx;
        cmd_arg   = ~arg;
        resp_long = ~rl;
        @(negedge clk);
    endtask

    task automatic wait_done(input logic [2:0] mask);
        int  n;
        bit  all;
        n   = 0;
        all = 0;
        while (!all && n < 6000) begin
            @(negedge clk);
            n++;
            all = 1;
            for (int g = 0; g < 3; g++)
                if (mask[g] && done_cnt[g] < 1) all = 0;
        end
        chk("wait_done_in_budget", 64'(all), 64'd1);
        repeat (4) @(negedge clk);
    endtask

    task automatic check_cmd(input string name, input logic [2:0] mask, input logic im,
                             input logic [5:0] idx, input logic [31:0] arg, input logic rl);
        logic [47:0] e_frame;
        logic [7:0]  e_r1;
        logic [31:0] e_data;
        logic        e_to;
        int          j, nbytes;
        e_frame = {2'b01, idx, arg, ref_crc7({2'b01, idx, arg}), 1'b1};
        for (int g = 0; g < 3; g++) begin
            if (mask[g]) begin
                j = -1;
                for (int p = 0; p < to_f(g); p++)
                    if (j < 0 && !rsp[p][7]) j = p;
                if (j >= 0) begin
                    e_r1   = rsp[j];
                    e_to   = 1'b0;
                    e_data = rl ? {rsp[j + 1], rsp[j + 2], rsp[j + 3], rsp[j + 4]} : 32'h0;
                    nbytes = 6 + j + 1 + (rl ? 4 : 0) + 1;
                end else begin
                    e_r1   = 8'hFF;
                    e_to   = 1'b1;
                    e_data = 32'h0;
                    nbytes = 6 + to_f(g) + 1;
                end
                chk($sformatf("%s.d%0d.frame", name, g), 64'(frame_cap[g]), 64'(e_frame));
                chk($sformatf("%s.d%0d.r1", name, g), 64'(resp_r1[g]), 64'(e_r1));
                chk($sformatf("%s.d%0d.data", name, g), 64'(resp_data[g]), 64'(e_data));
                chk($sformatf("%s.d%0d.timeout", name, g), 64'(timeout_err[g]), 64'(e_to));
                chk($sformatf("%s.d%0d.cs_low_clks", name, g), 64'(k[g]), 64'(8 * nbytes));
                chk($sformatf("%s.d%0d.preamble_clks", name, g), 64'(pre_clk[g]),
                    64'(im ? 8 * ib_f(g) : 0));
                chk($sformatf("%s.d%0d.mosi_not_ff", name, g), 64'(extra0[g]), 64'd0);
                chk($sformatf("%s.d%0d.done_pulses", name, g), 64'(done_cnt[g]), 64'd1);
                chk($sformatf("%s.d%0d.busy_with_done", name, g), 64'(bad_busy[g]), 64'd0);
                chk($sformatf("%s.d%0d.idle_lines", name, g),
                    64'({busy[g], cs[g], spi_clk[g], mosi[g]}), 64'b0101);
            end
        end
    endtask

    initial begin
        int         n;
        logic [5:0] r_idx;
        logic [31:0] r_arg, r_dat;
        logic       r_rl, r_im;

        rst_n     = 1'b0;
        cmd_start = '0;
        init_mode = 1'b0;
        resp_long = 1'b0;
        cmd_index = '0;
        cmd_arg   = '0;
        set_rsp(16, 8'hFF, 32'h0);
        repeat (3) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("reset.d%0d.lines", g),
                64'({busy[g], cmd_done[g], timeout_err[g], spi_clk[g], mosi[g], cs[g]}), 64'b000011);
            chk($sformatf("reset.d%0d.r1", g), 64'(resp_r1[g]), 64'hFF);
            chk($sformatf("reset.d%0d.data", g), 64'(resp_data[g]), 64'h0);
        end
        rst_n = 1'b1;

        set_rsp(1, 8'h01, 32'h0);
        start_cmd(3'b111, 1'b1, 6'd0, 32'h0, 1'b0);
        wait_done(3'b111);
        check_cmd("cmd0", 3'b111, 1'b1, 6'd0, 32'h0, 1'b0);
        chk("cmd0.frame_const", 64'(frame_cap[0]), 64'h400000000095);

        set_rsp(1, 8'h01, 32'h000001AA);
        start_cmd(3'b111, 1'b0, 6'd8, 32'h000001AA, 1'b1);
        wait_done(3'b111);
        check_cmd("cmd8", 3'b111, 1'b0, 6'd8, 32'h000001AA, 1'b1);
        chk("cmd8.frame_const", 64'(frame_cap[0]), 64'h48000001AA87);

        set_rsp(0, 8'h00, 32'h0);
        start_cmd(3'b111, 1'b0, 6'd55, 32'h0, 1'b0);
        wait_done(3'b111);
        check_cmd("cmd55", 3'b111, 1'b0, 6'd55, 32'h0, 1'b0);
        chk("cmd55.frame_const", 64'(frame_cap[0]), 64'h770000000065);
        start_cmd(3'b111, 1'b0, 6'd41, 32'h40000000, 1'b0);
        wait_done(3'b111);
        check_cmd("acmd41", 3'b111, 1'b0, 6'd41, 32'h40000000, 1'b0);
        chk("acmd41.frame_const", 64'(frame_cap[0]), 64'h694000000077);

        set_rsp(16, 8'hFF, 32'h0);
        start_cmd(3'b111, 1'b0, 6'd1, 32'h0, 1'b1);
        wait_done(3'b111);
        check_cmd("timeout", 3'b111, 1'b0, 6'd1, 32'h0, 1'b1);

        set_rsp(2, 8'h00, 32'h0);
        start_cmd(3'b111, 1'b0, 6'd17, $urandom, 1'b0);
        n = 0;
        while (k[0] < 20 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid.reached_byte3", 64'(n < 3000), 64'd1);
        chk("rst_mid.busy_before", 64'(busy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++)
            chk($sformatf("rst_mid.d%0d.lines", g),
                64'({busy[g], cs[g], spi_clk[g], mosi[g]}), 64'b0101);
        @(negedge clk);
        rst_n = 1'b1;
        set_rsp(1, 8'h01, 32'h0);
        start_cmd(3'b111, 1'b1, 6'd0, 32'h0, 1'b0);
        wait_done(3'b111);
        check_cmd("after_rst", 3'b111, 1'b1, 6'd0, 32'h0, 1'b0);

        set_rsp(0, 8'h01, 32'h0);
        start_cmd(3'b111, 1'b0, 6'd16, 32'h00000200, 1'b0);
        repeat (20) @(negedge clk);
        cmd_start = 3'b111;
        @(negedge clk);
        cmd_start = '0;
        n = 0;
        while (!cmd_done[0] && n < 6000) begin
            @(negedge clk);
            n++;
        end
        chk("ignore.saw_done", 64'(cmd_done[0]), 64'd1);
        cmd_start = 3'b001;
        @(negedge clk);
        cmd_start = '0;
        wait_done(3'b111);
        repeat (40) @(negedge clk);
        check_cmd("ignore", 3'b111, 1'b0, 6'd16, 32'h00000200, 1'b0);

        for (int it = 0; it < 8; it++) begin
            r_idx = 6'($urandom);
            r_arg = $urandom;
            r_dat = $urandom;
            r_rl  = 1'($urandom);
            r_im  = (it % 3 == 0);
            set_rsp(int'($urandom_range(0, 9)), 8'($urandom_range(0, 127)), r_dat);
            start_cmd(3'b111, r_im, r_idx, r_arg, r_rl);
            wait_done(3'b111);
            check_cmd($sformatf("rand%0d", it), 3'b111, r_im, r_idx, r_arg, r_rl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
